regfile_write_arbiter: RTL

Sequencer and arbiter for the 32×32 register file write port. It shares the single write port between two requesters, A (ALU writeback) and B (load writeback), using round-robin priority and a valid/ready handshake. It also runs a clear sweep that zeroes every register after reset or on command. It sits directly in front of the register file and drives that file's writeRegister, writeData and writeEnable inputs.

---
 rtl/regfile_pkg.sv | 13 +
 rtl/rr_arb2.sv | 34 +++
 rtl/regfile_write_arbiter.sv | 93 +++++++++
 3 files changed

// File: rtl/regfile_pkg.sv
// Shared defaults and FSM encoding for the register-file write sequencer.
package regfile_pkg;

    localparam int RF_ADDR_W   = 5;
    localparam int RF_DATA_W   = 32;
    localparam int RF_NUM_REGS = 32;

    typedef enum logic {
        CLEAR = 1'b0,
        ARB   = 1'b1
    } state_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin arbiter; the priority flop moves to the loser after each grant.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       enable,
    input  logic       advance,
    output logic [1:0] grant
);

    // 0 = requester 0 (A) wins a tie, 1 = requester 1 (B) wins a tie
    logic prio_b;

    always_comb begin
        grant = 2'b00;
        if (enable) begin
            case (req)
                2'b01:   grant = 2'b01;
                2'b10:   grant = 2'b10;
                2'b11:   grant = prio_b ? 2'b10 : 2'b01;
                default: grant = 2'b00;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prio_b <= 1'b0;
        end else if (advance) begin
            prio_b <= grant[0];
        end
    end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Shares the register-file write port between A and B (round-robin) and runs the clear sweep.
// Handshake: a write is accepted when valid && ready in the same cycle; ready never depends on a
// registered copy of valid, and requesters hold addr/data stable while valid && !ready.
module regfile_write_arbiter
    import regfile_pkg::*;
#(
    parameter int ADDR_W   = RF_ADDR_W,
    parameter int DATA_W   = RF_DATA_W,
    parameter int NUM_REGS = RF_NUM_REGS
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr_start,
    input  logic              a_valid,
    output logic              a_ready,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_data,
    input  logic              b_valid,
    output logic              b_ready,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_data,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              busy,
    output logic              clr_done,
    output state_t            dbg_state
);

    state_t            state;
    state_t            next_state;
    logic [ADDR_W-1:0] cnt;
    logic [1:0]        grant;
    logic              handshake;
    logic              sweep_last;
    logic              arb_enable;

    assign busy       = (state == CLEAR);
    assign dbg_state  = state;
    assign sweep_last = (cnt == ADDR_W'(NUM_REGS - 1));
    // clr_start outranks both requesters in the cycle it is seen
    assign arb_enable = (state == ARB) && !clr_start;

    rr_arb2 u_arb (
        .clk     (clk),
        .rst     (rst),
        .req     ({b_valid, a_valid}),
        .enable  (arb_enable),
        .advance (handshake),
        .grant   (grant)
    );

    assign a_ready   = grant[0];
    assign b_ready   = grant[1];
    assign handshake = (a_valid && a_ready) || (b_valid && b_ready);

    always_comb begin
        next_state = state;
        case (state)
            CLEAR:   if (sweep_last) next_state = ARB;
            ARB:     if (clr_start)  next_state = CLEAR;
            default: next_state = CLEAR;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= CLEAR;
            cnt      <= '0;
            wr_en    <= 1'b0;
            wr_addr  <= '0;
            wr_data  <= '0;
            clr_done <= 1'b0;
        end else begin
            state    <= next_state;
            wr_en    <= 1'b0;
            clr_done <= 1'b0;
            if (state == CLEAR) begin
                wr_en    <= 1'b1;
                wr_addr  <= cnt;
                wr_data  <= '0;
                clr_done <= sweep_last;
                cnt      <= sweep_last ? '0 : cnt + 1'b1;
            end else if (handshake) begin
                // wr_addr/wr_data only change on a real write; otherwise they hold
                wr_en   <= 1'b1;
                wr_addr <= grant[1] ? b_addr : a_addr;
                wr_data <= grant[1] ? b_data : a_data;
            end
        end
    end

endmodule
